// File: rtl/sp_ram_ctrl_if.sv
// Request/response bundle for sp_ram_ctrl: valid/ready request channel,
// read-response strobe, clear pulse and init status.
interface sp_ram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              clear;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W/8-1:0] req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_done;

  modport master (
    output clear, req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  clear, req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
endinterface

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM with byte-lane writes and a hardware zeroing sweep after reset/clear.
// Optional RAM_OUT_REG_EN adds an output register stage (read latency 2 instead of 1).
module sp_ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  sp_ram_ctrl_if.slave bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              acc_s;
  logic              wr_s;
  logic              rd_s;
  logic              in_range_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign bus.req_ready = (state_q == ST_RUN) & ~bus.clear;
  assign bus.init_done = (state_q == ST_RUN);
  assign acc_s         = bus.req_valid & bus.req_ready;
  assign wr_s          = acc_s & bus.req_we;
  assign rd_s          = acc_s & ~bus.req_we;
  assign in_range_s    = (32'(bus.req_addr) < 32'(DEPTH));

  // Sweep state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: sweep every word once, then serve requests until clear
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Out-of-range reads return zero rather than indexing past the array
  always_comb begin
    rd_word_s = '0;
    if (in_range_s) begin
      rd_word_s = mem_q[bus.req_addr];
    end else begin
      rd_word_s = '0;
    end
  end

  // Array storage: zeroed by the sweep, otherwise byte-lane writes
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_s && in_range_s) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.req_be[i]) begin
          mem_q[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

`ifdef RAM_OUT_REG_EN
  logic              rd_v1_q;
  logic [DATA_W-1:0] rd_d1_q;

  // Two-stage read pipeline; valid travels alongside the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1_q     <= 1'b0;
      rd_d1_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rd_v1_q     <= rd_s;
      if (rd_s) rd_d1_q <= rd_word_s;
      rsp_valid_q <= rd_v1_q;
      if (rd_v1_q) rsp_rdata_q <= rd_d1_q;
    end
  end
`else
  // Single-stage read; rdata holds between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rd_s;
      if (rd_s) rsp_rdata_q <= rd_word_s;
    end
  end
`endif

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed bench for sp_ram_ctrl (DEPTH=12, DATA_W=32) with a read-response scoreboard.
module tb_sp_ram_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 12;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   fails;

  logic [DW-1:0] model [16];
  logic [DW-1:0] exp_data_q [$];
  int            exp_cyc_q  [$];

  sp_ram_ctrl_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  sp_ram_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest outstanding read
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        check("rsp_data", bus.rsp_rdata, exp_data_q.pop_front());
        check("rsp_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
  end

  task automatic do_req(input logic we, input logic [3:0] addr,
                        input logic [DW-1:0] data, input logic [3:0] be);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    bus.req_be    = be;
    #1;
    check("req_ready", {31'd0, bus.req_ready}, 32'd1);
    if (we) begin
      if (addr < DEPTH) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[addr][8*i +: 8] = data[8*i +: 8];
      end
    end else begin
      exp_data_q.push_back((addr < DEPTH) ? model[addr] : 32'd0);
      exp_cyc_q.push_back(cyc + LAT);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.clear     = 1'b0;
    end
  endtask

  task automatic wait_init(input int exp_len);
    int n;
    n = 0;
    while (bus.init_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("init_len", 32'(n), 32'(exp_len));
  endtask

  task automatic zero_model();
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
  endtask

  initial begin
    cyc = 0; checks = 0; fails = 0;
    rst_n = 1'b0;
    bus.clear = 1'b0; bus.req_valid = 1'b0; bus.req_we = 1'b0;
    bus.req_addr = 4'd0; bus.req_wdata = 32'd0; bus.req_be = 4'd0;
    zero_model();

    #23;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_init_done", {31'd0, bus.init_done}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_init(DEPTH);

    for (int a = 0; a < DEPTH; a++) do_req(1'b0, 4'(a), 32'd0, 4'd0);

    do_req(1'b1, 4'd5, 32'h0000_0056, 4'hF);
    do_req(1'b0, 4'd5, 32'd0, 4'd0);
    do_req(1'b1, 4'd5, 32'h0000_0036, 4'hF);
    do_req(1'b0, 4'd5, 32'd0, 4'd0);

    do_req(1'b1, 4'd7, 32'hAABB_CCDD, 4'b1111);
    do_req(1'b1, 4'd7, 32'h1122_3344, 4'b0101);
    do_req(1'b0, 4'd7, 32'd0, 4'd0);
    do_req(1'b1, 4'd7, 32'hFFFF_FFFF, 4'b0000);
    do_req(1'b0, 4'd7, 32'd0, 4'd0);

    do_req(1'b1, 4'd1, 32'h11, 4'hF);
    do_req(1'b1, 4'd2, 32'h22, 4'hF);
    do_req(1'b1, 4'd3, 32'h33, 4'hF);
    do_req(1'b0, 4'd1, 32'd0, 4'd0);
    do_req(1'b0, 4'd2, 32'd0, 4'd0);
    do_req(1'b0, 4'd3, 32'd0, 4'd0);

    do_req(1'b1, 4'd13, 32'h77, 4'hF);
    do_req(1'b0, 4'd13, 32'd0, 4'd0);
    do_req(1'b0, 4'd1, 32'd0, 4'd0);

    // Read issued just before clear still returns pre-clear data
    do_req(1'b1, 4'd3, 32'h5A, 4'hF);
    do_req(1'b0, 4'd3, 32'd0, 4'd0);
    @(negedge clk);
    bus.clear = 1'b1; bus.req_valid = 1'b1; bus.req_we = 1'b1;
    bus.req_addr = 4'd0; bus.req_wdata = 32'h99; bus.req_be = 4'hF;
    #1;
    check("clear_ready", {31'd0, bus.req_ready}, 32'd1 - 32'd1);
    idle(1);
    zero_model();
    wait_init(DEPTH);
    do_req(1'b0, 4'd3, 32'd0, 4'd0);
    do_req(1'b0, 4'd0, 32'd0, 4'd0);

    // Reset in the middle of a sweep
    do_req(1'b1, 4'd4, 32'h44, 4'hF);
    do_req(1'b0, 4'd4, 32'd0, 4'd0);
    idle(3);
    check("rdata_hold", bus.rsp_rdata, 32'h44);
    @(negedge clk);
    bus.clear = 1'b1;
    idle(1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, bus.req_ready}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("mid_rst_rdata", bus.rsp_rdata, 32'd0);
    check("mid_rst_init_done", {31'd0, bus.init_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    zero_model();
    wait_init(DEPTH);
    do_req(1'b0, 4'd4, 32'd0, 4'd0);
    idle(4);

    check("q_empty", 32'(exp_data_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
